// File: rtl/io_bridge_pkg.sv
// io_bridge_pkg: shared IO map, bus widths and read-path types for the CPU IO bridge.
// Latency: n/a (constants and helpers only).
// Backpressure: n/a.
package io_bridge_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 32;

    localparam logic [17:0] IO_BASE = 18'h30000;
    localparam logic [17:0] IO_STAT = 18'h30004;
    localparam logic [1:0]  IO_SEL  = 2'b11;

    typedef enum logic {
        SRC_IO  = 1'b0,
        SRC_RAM = 1'b1
    } rd_src_e;

    // Registered read result: which source cpu_din shows, and the IO byte if any.
    typedef struct packed {
        rd_src_e           src;
        logic [DATA_W-1:0] dat;
    } rd_q_t;

    function automatic logic [DATA_W-1:0] snap_byte(input logic [CNT_W-1:0] s,
                                                    input logic [1:0]       idx);
        logic [DATA_W-1:0] b;
        case (idx)
            2'd0:    b = s[7:0];
            2'd1:    b = s[15:8];
            2'd2:    b = s[23:16];
            default: b = s[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/io_fifo.sv
// io_fifo: generic synchronous FIFO with occupancy count, full and empty flags.
// Latency: head visible the cycle after the first push (registered pointers).
// Backpressure: pushes while full and pops while empty are ignored.
module io_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     push_vld,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop_vld,
    output logic [W-1:0]             head_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          push_ok;
    logic          pop_ok;

    assign push_ok  = push_vld & ~full;
    assign pop_ok   = pop_vld & ~empty;
    assign full     = (cnt == DEPTH_C);
    assign empty    = (cnt == '0);
    assign count    = cnt;
    assign head_dat = mem[rd_ptr];

    // Storage carries no reset; pointer reset is what discards the contents.
    always_ff @(posedge clk_in) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + {{(AW-1){1'b0}}, 1'b1};
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + {{(AW-1){1'b0}}, 1'b1};
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + {{AW{1'b0}}, 1'b1};
                2'b01:   cnt <= cnt - {{AW{1'b0}}, 1'b1};
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/io_bridge.sv
// io_bridge: CPU bus decode to RAM/IO, UART TX FIFO, RX pop, cycle counter; RX path built with IO_BRIDGE_RX_EN.
// Latency: cpu_din valid exactly one cycle after the address; TX byte visible one cycle after the write.
// Backpressure: io_buffer_full at TX_DEPTH-2 entries; writes into a full FIFO drop and set tx_overflow.
module io_bridge
    import io_bridge_pkg::*;
#(
    parameter int TX_DEPTH = 16,
    parameter int RAM_AW   = 17
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic [ADDR_W-1:0]   cpu_a,
    input  logic [DATA_W-1:0]   cpu_dout,
    input  logic                cpu_wr,
    output logic [DATA_W-1:0]   cpu_din,
    output logic                io_buffer_full,
    output logic [RAM_AW-1:0]   ram_a,
    output logic [DATA_W-1:0]   ram_dout,
    output logic                ram_we,
    input  logic [DATA_W-1:0]   ram_din,
    output logic [DATA_W-1:0]   tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    input  logic [DATA_W-1:0]   rx_data,
    input  logic                rx_valid,
    output logic                rx_pop,
    output logic                prog_stop,
    output logic                tx_overflow
);

    localparam int FCW  = $clog2(TX_DEPTH) + 1;
    localparam int MARK = TX_DEPTH - 2;

    logic              io_sel;
    logic              hit_base;
    logic              hit_stat;
    logic              hit_snap;
    logic              wr_io;
    logic              rd_io;
    logic              push_vld;
    logic [DATA_W-1:0] push_dat;
    logic              pop_vld;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FCW-1:0]    fifo_count;
    logic              rx_take;
    logic [DATA_W-1:0] rx_byte;
    logic              addr_unused;

    logic [CNT_W-1:0]  cycle_cnt;
    logic [CNT_W-1:0]  snap_q;
    logic [CNT_W-1:0]  snap_d;
    rd_q_t             rd_q;
    rd_q_t             rd_d;
    logic              rx_pop_q;
    logic              prog_stop_q;
    logic              ovf_q;

    assign io_sel   = (cpu_a[17:16] == IO_SEL);
    assign hit_base = io_sel && (cpu_a[17:0] == IO_BASE);
    assign hit_stat = io_sel && (cpu_a[17:0] == IO_STAT);
    assign hit_snap = io_sel && (cpu_a[17:2] == IO_STAT[17:2]);
    assign wr_io    = rdy_in & cpu_wr & io_sel;
    assign rd_io    = rdy_in & ~cpu_wr & io_sel;

    assign addr_unused = ^cpu_a[ADDR_W-1:18];

    assign ram_a    = cpu_a[RAM_AW-1:0];
    assign ram_dout = cpu_dout;
    assign ram_we   = cpu_wr & ~io_sel & rdy_in;

    // A zero byte to the data port is a no-op; the stop port always queues a 0x00 marker.
    assign push_vld = wr_io & ((hit_base & (cpu_dout != '0)) | hit_stat);
    assign push_dat = hit_stat ? '0 : cpu_dout;
    assign pop_vld  = tx_valid & tx_ready & rdy_in;

`ifdef IO_BRIDGE_RX_EN
    assign rx_take = rd_io & hit_base & rx_valid;
    assign rx_byte = rx_take ? rx_data : '0;
`else
    logic rx_unused;
    assign rx_take   = 1'b0;
    assign rx_byte   = '0;
    assign rx_unused = ^{rx_data, rx_valid};
`endif

    io_fifo #(
        .DEPTH (TX_DEPTH),
        .W     (DATA_W)
    ) u_tx_fifo (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .pop_vld  (pop_vld),
        .head_dat (tx_data),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign tx_valid       = ~fifo_empty;
    assign io_buffer_full = (fifo_count >= MARK[FCW-1:0]);

    // With rdy_in low the read register and snapshot keep their value, which freezes cpu_din.
    always_comb begin
        rd_d   = rd_q;
        snap_d = snap_q;
        if (rdy_in) begin
            rd_d.src = io_sel ? SRC_IO : SRC_RAM;
            rd_d.dat = '0;
            if (rd_io) begin
                if (hit_base) begin
                    rd_d.dat = rx_byte;
                end else if (hit_snap) begin
                    if (cpu_a[1:0] == 2'd0) begin
                        rd_d.dat = cycle_cnt[7:0];
                        snap_d   = cycle_cnt;
                    end else begin
                        rd_d.dat = snap_byte(snap_q, cpu_a[1:0]);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cycle_cnt   <= '0;
            snap_q      <= '0;
            rd_q        <= '0;
            rx_pop_q    <= 1'b0;
            prog_stop_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            snap_q    <= snap_d;
            rd_q      <= rd_d;
            rx_pop_q  <= rx_take;
            if (wr_io && hit_stat) begin
                prog_stop_q <= 1'b1;
            end
            if (push_vld && fifo_full) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign cpu_din     = (rd_q.src == SRC_RAM) ? ram_din : rd_q.dat;
    assign rx_pop      = rx_pop_q;
    assign prog_stop   = prog_stop_q;
    assign tx_overflow = ovf_q;

endmodule

// File: tb/tb_io_bridge.sv
// tb_io_bridge: directed table plus hand-written sequences for the IO bridge.
// Inputs change 1 time unit after posedge; outputs are sampled away from the edge.
module tb_io_bridge;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic [31:0] cpu_a;
    logic [7:0]  cpu_dout;
    logic        cpu_wr;
    logic [7:0]  cpu_din;
    logic        io_buffer_full;
    logic [16:0] ram_a;
    logic [7:0]  ram_dout;
    logic        ram_we;
    logic [7:0]  ram_din;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_pop;
    logic        prog_stop;
    logic        tx_overflow;

`ifdef IO_BRIDGE_RX_EN
    localparam logic [7:0] RX_DIN = 8'h5A;
    localparam logic       RX_POP = 1'b1;
`else
    localparam logic [7:0] RX_DIN = 8'h00;
    localparam logic       RX_POP = 1'b0;
`endif

    io_bridge #(.TX_DEPTH(16), .RAM_AW(17)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .cpu_a          (cpu_a),
        .cpu_dout       (cpu_dout),
        .cpu_wr         (cpu_wr),
        .cpu_din        (cpu_din),
        .io_buffer_full (io_buffer_full),
        .ram_a          (ram_a),
        .ram_dout       (ram_dout),
        .ram_we         (ram_we),
        .ram_din        (ram_din),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_pop         (rx_pop),
        .prog_stop      (prog_stop),
        .tx_overflow    (tx_overflow)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Reference cycle count: cleared by reset, one step per rising edge.
    logic [31:0] mcnt;
    always @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) mcnt <= '0;
        else         mcnt <= mcnt + 32'd1;
    end

    // Bytes leaving the TX port: a handshake seen mid-cycle completes at the next edge.
    logic [7:0] txq[$];
    always @(negedge clk_in) begin
        if (rst_in && rdy_in && tx_valid && tx_ready) txq.push_back(tx_data);
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input logic wr, input logic [31:0] a, input logic [7:0] d);
        cpu_wr   = wr;
        cpu_a    = a;
        cpu_dout = d;
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] a;
        logic [7:0]  d;
        logic        rx_v;
        logic [7:0]  rx_d;
        logic [7:0]  rdin;
        logic        exp_we;
        logic [7:0]  exp_din;
        logic        exp_pop;
    } vec_t;

    vec_t vecs[9];
    logic [31:0] c0;

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; tx_ready = 1'b1;
        rx_valid = 1'b0; rx_data = 8'h00; ram_din = 8'h00;
        drive(1'b0, 32'h0, 8'h00);

        vecs[0] = '{1'b0, 32'h0000_0100, 8'h00, 1'b0, 8'h00, 8'hAB, 1'b0, 8'hAB, 1'b0};
        vecs[1] = '{1'b1, 32'h0000_0200, 8'h11, 1'b0, 8'h00, 8'h22, 1'b1, 8'h22, 1'b0};
        vecs[2] = '{1'b0, 32'h0003_0000, 8'h00, 1'b1, 8'h5A, 8'hEE, 1'b0, RX_DIN, RX_POP};
        vecs[3] = '{1'b0, 32'h0003_0000, 8'h00, 1'b0, 8'h77, 8'hEE, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{1'b0, 32'h0003_0008, 8'h00, 1'b1, 8'h33, 8'hFF, 1'b0, 8'h00, 1'b0};
        vecs[5] = '{1'b0, 32'h0003_0001, 8'h00, 1'b0, 8'h00, 8'hFF, 1'b0, 8'h00, 1'b0};
        vecs[6] = '{1'b0, 32'h0001_0005, 8'h00, 1'b0, 8'h00, 8'h3C, 1'b0, 8'h3C, 1'b0};
        vecs[7] = '{1'b1, 32'h0003_0010, 8'h55, 1'b0, 8'h00, 8'hC1, 1'b0, 8'h00, 1'b0};
        vecs[8] = '{1'b0, 32'h0002_0000, 8'h00, 1'b0, 8'h00, 8'h77, 1'b0, 8'h77, 1'b0};

        // Reset state, checked while reset is still asserted.
        repeat (3) tick();
        chk("rst_cpu_din", {24'h0, cpu_din}, 32'h0);
        chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        chk("rst_prog_stop", {31'h0, prog_stop}, 32'h0);
        chk("rst_tx_overflow", {31'h0, tx_overflow}, 32'h0);
        chk("rst_rx_pop", {31'h0, rx_pop}, 32'h0);
        chk("rst_buf_full", {31'h0, io_buffer_full}, 32'h0);
        rst_in = 1'b1;
        tick();

        // Decode and read-path table, one vector per cycle.
        txq.delete();
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].wr, vecs[i].a, vecs[i].d);
            rx_valid = vecs[i].rx_v;
            rx_data  = vecs[i].rx_d;
            #1;
            chk($sformatf("vec%0d_ram_we", i), {31'h0, ram_we}, {31'h0, vecs[i].exp_we});
            @(posedge clk_in);
            #1;
            ram_din = vecs[i].rdin;
            #1;
            chk($sformatf("vec%0d_cpu_din", i), {24'h0, cpu_din}, {24'h0, vecs[i].exp_din});
            chk($sformatf("vec%0d_rx_pop", i), {31'h0, rx_pop}, {31'h0, vecs[i].exp_pop});
        end
        rx_valid = 1'b0;
        drive(1'b0, 32'h0012_0100, 8'h00);
        #1;
        chk("ram_a_trunc", {15'h0, ram_a}, 32'h0000_0100);
        chk("ram_we_read", {31'h0, ram_we}, 32'h0);
        tick();
        repeat (2) tick();
        chk("no_stray_tx", txq.size(), 32'd0);

        // TX data port: the zero byte is swallowed.
        txq.delete();
        drive(1'b1, 32'h0003_0000, 8'h41); tick();
        drive(1'b1, 32'h0003_0000, 8'h00); tick();
        drive(1'b1, 32'h0003_0000, 8'h42); tick();
        drive(1'b0, 32'h0000_0100, 8'h00);
        repeat (4) tick();
        chk("tx_seq_len", txq.size(), 32'd2);
        chk("tx_seq_0", {24'h0, txq[0]}, 32'h41);
        chk("tx_seq_1", {24'h0, txq[1]}, 32'h42);

        // Fill with the UART stalled: full mark at 14, two more fit, the third drops.
        txq.delete();
        tx_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 32'h0003_0000, 8'(i + 1));
            tick();
            if (i == 12) chk("full_at_13", {31'h0, io_buffer_full}, 32'h0);
            if (i == 13) chk("full_at_14", {31'h0, io_buffer_full}, 32'h1);
            if (i == 15) chk("ovf_at_16", {31'h0, tx_overflow}, 32'h0);
        end
        chk("ovf_at_17", {31'h0, tx_overflow}, 32'h1);
        drive(1'b0, 32'h0000_0100, 8'h00);
        tx_ready = 1'b1;
        repeat (20) tick();
        chk("drain_len", txq.size(), 32'd16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain_%0d", i), {24'h0, txq[i]}, i + 1);
        end
        chk("ovf_sticky", {31'h0, tx_overflow}, 32'h1);

        // Stop port: sticky flag plus a 0x00 marker on TX.
        txq.delete();
        chk("stop_before", {31'h0, prog_stop}, 32'h0);
        drive(1'b1, 32'h0003_0004, 8'h99); tick();
        chk("stop_set", {31'h0, prog_stop}, 32'h1);
        drive(1'b0, 32'h0000_0100, 8'h00);
        repeat (3) tick();
        chk("stop_hold", {31'h0, prog_stop}, 32'h1);
        chk("stop_tx_len", txq.size(), 32'd1);
        chk("stop_tx_byte", {24'h0, txq[0]}, 32'h00);

        // Pending counter read frozen by rdy_in low for 5 cycles.
        tx_ready = 1'b0;
        drive(1'b1, 32'h0003_0000, 8'h61); tick();
        drive(1'b1, 32'h0003_0000, 8'h62); tick();
        txq.delete();
        drive(1'b0, 32'h0003_0004, 8'h00);
        c0 = mcnt;
        tick();
        chk("snap_b0", {24'h0, cpu_din}, {24'h0, c0[7:0]});
        rdy_in = 1'b0;
        tx_ready = 1'b1;
        repeat (5) tick();
        chk("freeze_din", {24'h0, cpu_din}, {24'h0, c0[7:0]});
        chk("freeze_tx_valid", {31'h0, tx_valid}, 32'h1);
        chk("freeze_tx_head", {24'h0, tx_data}, 32'h61);
        chk("freeze_no_pop", txq.size(), 32'd0);
        rdy_in = 1'b1;
        tx_ready = 1'b0;
        drive(1'b0, 32'h0003_0005, 8'h00); tick();
        chk("snap_b1", {24'h0, cpu_din}, {24'h0, c0[15:8]});
        drive(1'b0, 32'h0003_0006, 8'h00); tick();
        chk("snap_b2", {24'h0, cpu_din}, {24'h0, c0[23:16]});
        drive(1'b0, 32'h0003_0007, 8'h00); tick();
        chk("snap_b3", {24'h0, cpu_din}, {24'h0, c0[31:24]});
        drive(1'b0, 32'h0003_0004, 8'h00); tick();
        c0 = c0 + 32'd9;
        chk("cnt_ran_in_freeze", {24'h0, cpu_din}, {24'h0, c0[7:0]});

        // Asynchronous reset in the middle of a burst with a read pending.
        drive(1'b1, 32'h0003_0000, 8'h63); tick();
        drive(1'b0, 32'h0003_0000, 8'h00);
        rx_valid = 1'b1; rx_data = 8'h5A;
        tick();
        #2;
        rst_in = 1'b0;
        #1;
        chk("mid_rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        chk("mid_rst_cpu_din", {24'h0, cpu_din}, 32'h0);
        chk("mid_rst_prog_stop", {31'h0, prog_stop}, 32'h0);
        chk("mid_rst_overflow", {31'h0, tx_overflow}, 32'h0);
        chk("mid_rst_rx_pop", {31'h0, rx_pop}, 32'h0);
        chk("mid_rst_buf_full", {31'h0, io_buffer_full}, 32'h0);
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        drive(1'b0, 32'h0003_0004, 8'h00);
        #3;
        rst_in = 1'b1;
        tick();
        chk("post_rst_cnt0", {24'h0, cpu_din}, 32'h00);
        tick();
        chk("post_rst_cnt1", {24'h0, cpu_din}, 32'h01);
        chk("post_rst_empty", {31'h0, tx_valid}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
